// File: rtl/crc_frame_check.sv
// Receive-side CRC-32 frame checker: strips the trailing 32-bit FCS, forwards payload, reports per-frame status.
// Optional good/bad frame counters are enabled by defining CRC_STAT_CNT_EN.
module crc_frame_check #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_data,
    input  logic             s_sof,
    input  logic             s_eof,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      m_data,
    output logic             m_sof,
    output logic             m_eof,
    output logic             stat_valid,
    output logic             stat_good,
    output logic             stat_runt,
    output logic             stat_abort,
    output logic [LEN_W-1:0] stat_len
`ifdef CRC_STAT_CNT_EN
    ,
    input  logic             clr_cnt,
    output logic [15:0]      cnt_good,
    output logic [15:0]      cnt_bad
`endif
);

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {IDLE, FILL1, FULL} state_t;

    // Sixteen MSB-first serial steps folded into one cycle; no reflection or final inversion.
    function automatic logic [31:0] crc16_upd(input logic [31:0] crc, input logic [15:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    state_t             state_q;
    logic [31:0]        crc_q;
    logic [15:0]        w0_q, w1_q;
    logic [LEN_W-1:0]   len_q;
    logic               m_valid_q, m_sof_q, m_eof_q;
    logic [15:0]        m_data_q;
    logic               stat_valid_q, stat_good_q, stat_runt_q, stat_abort_q;
    logic [LEN_W-1:0]   stat_len_q;

    logic               s_acc, m_acc;
    logic [31:0]        crc_w0_d;
    logic [LEN_W-1:0]   len_inc_d;

    assign s_ready   = !m_valid_q | m_ready;
    assign s_acc     = s_valid & s_ready;
    assign m_acc     = m_valid_q & m_ready;
    assign crc_w0_d  = crc16_upd(crc_q, w0_q);
    assign len_inc_d = (&len_q) ? len_q : len_q + 1'b1;

    // NOTE: every register here updates with <=, so all reads in this block see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            crc_q        <= CRC_INIT;
            w0_q         <= '0;
            w1_q         <= '0;
            len_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_sof_q      <= 1'b0;
            m_eof_q      <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_good_q  <= 1'b0;
            stat_runt_q  <= 1'b0;
            stat_abort_q <= 1'b0;
            stat_len_q   <= '0;
        end else begin
            stat_valid_q <= 1'b0;
            stat_good_q  <= 1'b0;
            stat_runt_q  <= 1'b0;
            stat_abort_q <= 1'b0;
            stat_len_q   <= '0;
            if (m_acc) m_valid_q <= 1'b0;

            if (s_acc) begin
                if (s_sof) begin
                    // A sof mid-frame aborts the held frame; abort reporting wins over a same-word runt.
                    if (state_q != IDLE) begin
                        stat_valid_q <= 1'b1;
                        stat_abort_q <= 1'b1;
                        stat_len_q   <= len_q;
                    end else if (s_eof) begin
                        stat_valid_q <= 1'b1;
                        stat_runt_q  <= 1'b1;
                    end
                    crc_q   <= CRC_INIT;
                    len_q   <= '0;
                    w0_q    <= s_data;
                    state_q <= s_eof ? IDLE : FILL1;
                end else begin
                    case (state_q)
                        IDLE: ;
                        FILL1: begin
                            if (s_eof) begin
                                stat_valid_q <= 1'b1;
                                stat_good_q  <= (crc_q == {w0_q, s_data});
                                state_q      <= IDLE;
                            end else begin
                                w1_q    <= s_data;
                                state_q <= FULL;
                            end
                        end
                        FULL: begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= w0_q;
                            m_sof_q   <= (len_q == '0);
                            m_eof_q   <= s_eof;
                            crc_q     <= crc_w0_d;
                            len_q     <= len_inc_d;
                            w0_q      <= w1_q;
                            w1_q      <= s_data;
                            if (s_eof) begin
                                stat_valid_q <= 1'b1;
                                stat_good_q  <= (crc_w0_d == {w1_q, s_data});
                                stat_len_q   <= len_inc_d;
                                state_q      <= IDLE;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_sof      = m_sof_q;
    assign m_eof      = m_eof_q;
    assign stat_valid = stat_valid_q;
    assign stat_good  = stat_good_q;
    assign stat_runt  = stat_runt_q;
    assign stat_abort = stat_abort_q;
    assign stat_len   = stat_len_q;

`ifdef CRC_STAT_CNT_EN
    logic [15:0] cnt_good_q, cnt_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_good_q <= '0;
            cnt_bad_q  <= '0;
        end else if (clr_cnt) begin
            cnt_good_q <= '0;
            cnt_bad_q  <= '0;
        end else if (stat_valid_q) begin
            if (stat_good_q && !(&cnt_good_q)) cnt_good_q <= cnt_good_q + 1'b1;
            if (!stat_good_q && !(&cnt_bad_q)) cnt_bad_q <= cnt_bad_q + 1'b1;
        end
    end

    assign cnt_good = cnt_good_q;
    assign cnt_bad  = cnt_bad_q;
`endif

endmodule
